// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: states, opcodes and datapath selects.
// The CTRL_BNE_EN macro decides whether bne counts as a supported opcode.
package mips_ctrl_pkg;

    localparam int OPW  = 6;
    localparam int ST_W = 4;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_ALU_WB  = 4'd7,
        S_BRANCH  = 4'd8,
        S_EXEC_I  = 4'd9,
        S_JUMP    = 4'd10
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;

    localparam logic [1:0] SRC_B_REG   = 2'b00;
    localparam logic [1:0] SRC_B_FOUR  = 2'b01;
    localparam logic [1:0] SRC_B_IMM   = 2'b10;
    localparam logic [1:0] SRC_B_IMMSH = 2'b11;

    localparam logic [1:0] PC_SRC_ALU  = 2'b00;
    localparam logic [1:0] PC_SRC_OUT  = 2'b01;
    localparam logic [1:0] PC_SRC_JUMP = 2'b10;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_supported = 1'b1;
`ifdef CTRL_BNE_EN
            OP_BNE:  op_supported = 1'b1;
`endif
            default: op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational state -> control-vector decoder; memory-state write enables are gated by mem_ready.
// With CTRL_BNE_EN undefined, branch_ne is held at 0.
module ctrl_out_decode
    import mips_ctrl_pkg::*;
#(
    parameter int OPW = 6
) (
    input  state_t         state,
    input  logic [OPW-1:0] opcode,
    input  logic           mem_ready,
    output logic           pc_write,
    output logic           pc_write_cond,
    output logic           branch_ne,
    output logic           iord,
    output logic           mem_read,
    output logic           mem_write,
    output logic           ir_write,
    output logic           mem_to_reg,
    output logic           reg_dst,
    output logic           reg_write,
    output logic           alu_src_a,
    output logic [1:0]     alu_src_b,
    output logic [2:0]     alu_op,
    output logic [1:0]     pc_src
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SRC_B_REG;
        alu_op        = ALU_ADD;
        pc_src        = PC_SRC_ALU;
        case (state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRC_B_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE:  alu_src_b = SRC_B_IMMSH;
            S_MEM_ADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = mem_ready;
                iord      = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            // IR is frozen outside FETCH, so the opcode still identifies the R-type path here
            S_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = (opcode == OP_R);
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = ALU_SUB;
                pc_write_cond = 1'b1;
                pc_src        = PC_SRC_OUT;
`ifdef CTRL_BNE_EN
                branch_ne     = (opcode == OP_BNE);
`endif
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    default: alu_op = ALU_ADD;
                endcase
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pc_src   = PC_SRC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle MIPS datapath: state register, next-state logic, ext_u register.
// Optional bne support is enabled by defining CTRL_BNE_EN.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int OPW  = 6,
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OPW-1:0]  opcode,
    input  logic            mem_ready,
    input  logic            alu_zero,
    output logic            pc_write,
    output logic            pc_write_cond,
    output logic            branch_ne,
    output logic            iord,
    output logic            mem_read,
    output logic            mem_write,
    output logic            ir_write,
    output logic            mem_to_reg,
    output logic            reg_dst,
    output logic            reg_write,
    output logic            alu_src_a,
    output logic [1:0]      alu_src_b,
    output logic [2:0]      alu_op,
    output logic [1:0]      pc_src,
    output logic            ext_u,
    output logic            illegal_op,
    output logic [ST_W-1:0] state
);

    state_t state_reg;
    state_t state_next;
    logic   ext_u_reg;
    logic   alu_zero_unused;

    // The branch decision is taken in the datapath; the flag is only observed there.
    assign alu_zero_unused = alu_zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_FETCH;
            ext_u_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_DECODE)
                ext_u_reg <= (opcode == OP_ANDI) || (opcode == OP_ORI);
        end
    end

    always_comb begin
        state_next = S_FETCH;
        case (state_reg)
            S_FETCH: state_next = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:             state_next = S_MEM_ADR;
                    OP_R:                     state_next = S_EXEC_R;
                    OP_BEQ:                   state_next = S_BRANCH;
`ifdef CTRL_BNE_EN
                    OP_BNE:                   state_next = S_BRANCH;
`endif
                    OP_ADDI, OP_ANDI, OP_ORI: state_next = S_EXEC_I;
                    OP_J:                     state_next = S_JUMP;
                    default:                  state_next = S_FETCH;
                endcase
            end
            S_MEM_ADR: state_next = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  state_next = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:  state_next = S_FETCH;
            S_MEM_WR:  state_next = mem_ready ? S_FETCH : S_MEM_WR;
            S_EXEC_R:  state_next = S_ALU_WB;
            S_ALU_WB:  state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_EXEC_I:  state_next = S_ALU_WB;
            S_JUMP:    state_next = S_FETCH;
            default:   state_next = S_FETCH;
        endcase
    end

    always_comb begin
        illegal_op = (state_reg == S_DECODE) && !op_supported(opcode);
        ext_u      = ext_u_reg;
        state      = state_reg;
    end

    ctrl_out_decode #(.OPW(OPW)) u_decode (
        .state         (state_reg),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src)
    );

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed testbench for multicycle_ctrl_fsm; expectations follow the per-state control table.
// bne expectations switch on CTRL_BNE_EN.
module tb_multicycle_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       alu_zero;
    logic       pc_write, pc_write_cond, branch_ne, iord, mem_read, mem_write;
    logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_op;
    logic       ext_u, illegal_op;
    logic [3:0] state;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm #(.OPW(6), .ST_W(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .alu_zero      (alu_zero),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .branch_ne     (branch_ne),
        .iord          (iord),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_src        (pc_src),
        .ext_u         (ext_u),
        .illegal_op    (illegal_op),
        .state         (state)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
            $display("check %-18s got %0d exp %0d ok", tag, got, exp);
        end else begin
            $display("FAIL %-18s got %0d exp %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        opcode    = 6'b000000;
        alu_zero  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state",    8'(state), 8'd0);
        check("rst_ext_u",    8'(ext_u), 8'd0);
        check("rst_illegal",  8'(illegal_op), 8'd0);
        check("rst_mem_read", 8'(mem_read), 8'd1);
        rst_n = 1'b1;

        // FETCH holds while memory is not ready
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_state",    8'(state), 8'd0);
            check("hold_ir_write", 8'(ir_write), 8'd0);
            check("hold_pc_write", 8'(pc_write), 8'd0);
            check("hold_mem_read", 8'(mem_read), 8'd1);
        end

        // lw: 0,1,2,3,4,0
        opcode = 6'b100011; mem_ready = 1'b1; #1;
        check("lw_f_ir_write",  8'(ir_write), 8'd1);
        check("lw_f_pc_write",  8'(pc_write), 8'd1);
        check("lw_f_src_b",     8'(alu_src_b), 8'd1);
        check("lw_f_iord",      8'(iord), 8'd0);
        tick();
        check("lw_d_state",     8'(state), 8'd1);
        check("lw_d_src_b",     8'(alu_src_b), 8'd3);
        check("lw_d_alu_op",    8'(alu_op), 8'd0);
        check("lw_d_illegal",   8'(illegal_op), 8'd0);
        tick();
        check("lw_a_state",     8'(state), 8'd2);
        check("lw_a_src_a",     8'(alu_src_a), 8'd1);
        check("lw_a_src_b",     8'(alu_src_b), 8'd2);
        check("lw_a_ext_u",     8'(ext_u), 8'd0);
        tick();
        check("lw_r_state",     8'(state), 8'd3);
        check("lw_r_mem_read",  8'(mem_read), 8'd1);
        check("lw_r_iord",      8'(iord), 8'd1);
        tick();
        check("lw_wb_state",    8'(state), 8'd4);
        check("lw_wb_reg_write",8'(reg_write), 8'd1);
        check("lw_wb_mem2reg",  8'(mem_to_reg), 8'd1);
        check("lw_wb_reg_dst",  8'(reg_dst), 8'd0);
        tick();
        check("lw_end_state",   8'(state), 8'd0);

        // andi: 0,1,9,7,0
        opcode = 6'b001100;
        tick();
        check("andi_d_state",   8'(state), 8'd1);
        check("andi_d_ext_u",   8'(ext_u), 8'd0);
        tick();
        check("andi_x_state",   8'(state), 8'd9);
        check("andi_x_ext_u",   8'(ext_u), 8'd1);
        check("andi_x_alu_op",  8'(alu_op), 8'd3);
        check("andi_x_src_b",   8'(alu_src_b), 8'd2);
        tick();
        check("andi_wb_state",  8'(state), 8'd7);
        check("andi_wb_regwr",  8'(reg_write), 8'd1);
        check("andi_wb_reg_dst",8'(reg_dst), 8'd0);
        check("andi_wb_mem2reg",8'(mem_to_reg), 8'd0);
        tick();
        check("andi_end_state", 8'(state), 8'd0);
        check("andi_end_ext_u", 8'(ext_u), 8'd1);

        // beq: 0,1,8,0
        opcode = 6'b000100;
        tick();
        check("beq_d_state",    8'(state), 8'd1);
        tick();
        check("beq_b_state",    8'(state), 8'd8);
        check("beq_b_pcwc",     8'(pc_write_cond), 8'd1);
        check("beq_b_pc_src",   8'(pc_src), 8'd1);
        check("beq_b_alu_op",   8'(alu_op), 8'd1);
        check("beq_b_bne",      8'(branch_ne), 8'd0);
        check("beq_b_ext_u",    8'(ext_u), 8'd0);
        tick();
        check("beq_end_state",  8'(state), 8'd0);

        // R-type: 0,1,6,7,0
        opcode = 6'b000000;
        tick();
        tick();
        check("r_x_state",      8'(state), 8'd6);
        check("r_x_alu_op",     8'(alu_op), 8'd2);
        check("r_x_src_b",      8'(alu_src_b), 8'd0);
        tick();
        check("r_wb_state",     8'(state), 8'd7);
        check("r_wb_reg_dst",   8'(reg_dst), 8'd1);
        tick();
        check("r_end_state",    8'(state), 8'd0);

        // j: 0,1,10,0
        opcode = 6'b000010;
        tick();
        tick();
        check("j_state",        8'(state), 8'd10);
        check("j_pc_write",     8'(pc_write), 8'd1);
        check("j_pc_src",       8'(pc_src), 8'd2);
        tick();
        check("j_end_state",    8'(state), 8'd0);

        // ori: 0,1,9,7,0
        opcode = 6'b001101;
        tick();
        tick();
        check("ori_x_state",    8'(state), 8'd9);
        check("ori_x_alu_op",   8'(alu_op), 8'd4);
        check("ori_x_ext_u",    8'(ext_u), 8'd1);
        tick();
        check("ori_wb_state",   8'(state), 8'd7);
        tick();

        // addi clears ext_u and uses add
        opcode = 6'b001000;
        tick();
        tick();
        check("addi_x_state",   8'(state), 8'd9);
        check("addi_x_alu_op",  8'(alu_op), 8'd0);
        check("addi_x_ext_u",   8'(ext_u), 8'd0);
        tick();
        tick();
        check("addi_end_state", 8'(state), 8'd0);

        // bne
        opcode = 6'b000101;
        tick();
        check("bne_d_state",    8'(state), 8'd1);
`ifdef CTRL_BNE_EN
        check("bne_d_illegal",  8'(illegal_op), 8'd0);
        tick();
        check("bne_b_state",    8'(state), 8'd8);
        check("bne_b_bne",      8'(branch_ne), 8'd1);
        tick();
`else
        check("bne_d_illegal",  8'(illegal_op), 8'd1);
        tick();
        check("bne_next_state", 8'(state), 8'd0);
        check("bne_next_illeg", 8'(illegal_op), 8'd0);
`endif

        // unsupported opcode
        opcode = 6'b111111;
        tick();
        check("ill_d_illegal",  8'(illegal_op), 8'd1);
        tick();
        check("ill_next_state", 8'(state), 8'd0);
        check("ill_next_illeg", 8'(illegal_op), 8'd0);

        // sw with two wait cycles in MEM_WR
        opcode = 6'b101011;
        tick();
        tick();
        check("sw_a_state",     8'(state), 8'd2);
        mem_ready = 1'b0;
        tick();
        check("sw_w1_state",    8'(state), 8'd5);
        check("sw_w1_mem_write",8'(mem_write), 8'd0);
        check("sw_w1_iord",     8'(iord), 8'd1);
        tick();
        check("sw_w2_state",    8'(state), 8'd5);
        check("sw_w2_mem_write",8'(mem_write), 8'd0);
        mem_ready = 1'b1; #1;
        check("sw_w3_mem_write",8'(mem_write), 8'd1);
        tick();
        check("sw_end_state",   8'(state), 8'd0);

        // sw aborted by reset while waiting in MEM_WR
        tick();
        tick();
        mem_ready = 1'b0;
        tick();
        check("swr_state",      8'(state), 8'd5);
        mem_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        check("swr_rst_state",  8'(state), 8'd0);
        check("swr_rst_mwrite", 8'(mem_write), 8'd0);
        tick();
        check("swr_hold_state", 8'(state), 8'd0);
        check("swr_hold_mwrite",8'(mem_write), 8'd0);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
